// File: rtl/alu_pipe_pkg.sv
// Shared types for the two-stage pipelined ALU: opcode encoding and the
// packed flag bundle carried alongside each result.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } alu_flags_t;

endpackage

// File: rtl/alu_addsub.sv
// Nibble-wise carry-select adder/subtractor. Subtraction is A + ~B + 1, so the
// raw carry-out is returned and the caller turns it into a borrow.
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NIB = WIDTH / 4;

    logic [WIDTH-1:0] b_eff;
    logic [NIB:0]     c_chain;
    logic [3:0]       msb_in0;
    logic [3:0]       msb_in1;
    logic             c_into_msb;

    assign b_eff      = sub ? ~b : b;
    assign c_chain[0] = sub;

    // Each nibble precomputes both carry-in cases; the ripple only drives muxes.
    for (genvar i = 0; i < NIB; i++) begin : g_nib
        logic [3:0] a_n;
        logic [3:0] b_n;
        logic [4:0] r0;
        logic [4:0] r1;

        assign a_n = a[4*i +: 4];
        assign b_n = b_eff[4*i +: 4];
        assign r0  = {1'b0, a_n} + {1'b0, b_n};
        assign r1  = {1'b0, a_n} + {1'b0, b_n} + 5'd1;

        assign sum[4*i +: 4] = c_chain[i] ? r1[3:0] : r0[3:0];
        assign c_chain[i+1]  = c_chain[i] ? r1[4]   : r0[4];
    end

    // Overflow needs the carry into the MSB, taken from the top nibble's low 3 bits.
    assign msb_in0    = {1'b0, a[WIDTH-2 -: 3]} + {1'b0, b_eff[WIDTH-2 -: 3]};
    assign msb_in1    = {1'b0, a[WIDTH-2 -: 3]} + {1'b0, b_eff[WIDTH-2 -: 3]} + 4'd1;
    assign c_into_msb = c_chain[NIB-1] ? msb_in1[3] : msb_in0[3];

    assign carry    = c_chain[NIB];
    assign overflow = c_into_msb ^ c_chain[NIB];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides: stage 1 holds the
// operands, stage 2 holds the result and flags, plus a sticky overflow bit.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_c,
    output logic             out_v,
    output logic             out_n,
    output logic             out_z,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_e          s1_op;

    logic             s1_load;
    logic             s2_load;

    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;

    logic [WIDTH-1:0] nxt_result;
    alu_flags_t       nxt_flags;
    alu_flags_t       out_flags;

    // Stall path is combinational from out_ready so a full pipe can still take
    // a new op in the same cycle the consumer drains the output.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= alu_op_e'(in_op);
            end
        end
    end

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (s1_a),
        .b        (s1_b),
        .sub      (s1_op == OP_SUB),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    // One extra bit on each side catches the last bit shifted out; with a zero
    // amount that bit stays 0.
    assign shl_ext = {1'b0, s1_a} << s1_b[SHW-1:0];
    assign shr_ext = {s1_a, 1'b0} >> s1_b[SHW-1:0];

    always_comb begin
        nxt_result = '0;
        nxt_flags  = '0;
        case (s1_op)
            OP_ADD: begin
                nxt_result  = as_sum;
                nxt_flags.c = as_carry;
                nxt_flags.v = as_ovf;
                nxt_flags.n = as_sum[WIDTH-1];
            end
            OP_SUB: begin
                nxt_result  = as_sum;
                nxt_flags.c = ~as_carry;
                nxt_flags.v = as_ovf;
                nxt_flags.n = as_sum[WIDTH-1];
            end
            OP_AND: nxt_result = s1_a & s1_b;
            OP_OR:  nxt_result = s1_a | s1_b;
            OP_XOR: nxt_result = s1_a ^ s1_b;
            OP_NOT: nxt_result = ~s1_a;
            OP_SHL: begin
                nxt_result  = shl_ext[WIDTH-1:0];
                nxt_flags.c = shl_ext[WIDTH];
            end
            OP_SHR: begin
                nxt_result  = shr_ext[WIDTH:1];
                nxt_flags.c = shr_ext[0];
            end
            default: nxt_result = '0;
        endcase
        nxt_flags.z = (nxt_result == '0);
    end

    // Result and flags only move when stage 2 advances with a live op, so they
    // hold steady for the whole time out_valid waits on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= nxt_result;
                out_flags  <= nxt_flags;
            end
        end
    end

    // A set from an overflowing output transfer takes priority over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_flags.v) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

    assign out_c = out_flags.c;
    assign out_v = out_flags.v;
    assign out_n = out_flags.n;
    assign out_z = out_flags.z;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=16: a vector table for the datapath and
// flags, then hand-written backpressure, sticky-overflow and reset sequences.
module tb_alu_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_c;
    logic        out_v;
    logic        out_n;
    logic        out_z;
    logic        ovf_sticky;
    logic        clr_sticky;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_r;
        logic [3:0]  exp_f;
    } vec_t;

    vec_t vecs [15];

    alu_pipe #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_c      (out_c),
        .out_v      (out_v),
        .out_n      (out_n),
        .out_z      (out_z),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Presents one op, lets it be accepted, and leaves time 1ns after the edge
    // at which it reaches the output register.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        checkOutput("accept_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0110};
        vecs[1]  = '{3'b001, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010};
        vecs[2]  = '{3'b001, 16'h1234, 16'h1234, 16'h0000, 4'b0001};
        vecs[3]  = '{3'b110, 16'h8001, 16'h0001, 16'h0002, 4'b1000};
        vecs[4]  = '{3'b111, 16'h0003, 16'h0001, 16'h0001, 4'b1000};
        vecs[5]  = '{3'b110, 16'h1234, 16'h0000, 16'h1234, 4'b0000};
        vecs[6]  = '{3'b100, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0001};
        vecs[7]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001};
        vecs[8]  = '{3'b010, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000};
        vecs[9]  = '{3'b011, 16'hF000, 16'h000F, 16'hF00F, 4'b0000};
        vecs[10] = '{3'b101, 16'h00FF, 16'h0000, 16'hFF00, 4'b0000};
        vecs[11] = '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0100};
        vecs[12] = '{3'b111, 16'h8000, 16'h000F, 16'h0001, 4'b0000};
        vecs[13] = '{3'b110, 16'hC001, 16'h0002, 16'h0004, 4'b1000};
        vecs[14] = '{3'b000, 16'h1234, 16'h4321, 16'h5555, 4'b0000};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_op      = '0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;

        #12;
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_result", {16'b0, out_result}, 32'd0);
        checkOutput("reset_flags", {28'b0, out_c, out_v, out_n, out_z}, 32'd0);
        checkOutput("reset_sticky", {31'b0, ovf_sticky}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 checkOutput("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Datapath and flags, one op at a time with the consumer always ready.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            checkOutput($sformatf("vec%0d_result", i), {16'b0, out_result}, {16'b0, vecs[i].exp_r});
            checkOutput($sformatf("vec%0d_cvnz", i), {28'b0, out_c, out_v, out_n, out_z}, {28'b0, vecs[i].exp_f});
            if (i == 0) begin
                checkOutput("sticky_before_xfer", {31'b0, ovf_sticky}, 32'd0);
                @(posedge clk);
                #1 checkOutput("sticky_after_xfer", {31'b0, ovf_sticky}, 32'd1);
            end
        end
        @(posedge clk);
        #1 checkOutput("drained_after_table", {31'b0, out_valid}, 32'd0);

        // Clear alone drops the sticky bit.
        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        checkOutput("sticky_cleared", {31'b0, ovf_sticky}, 32'd0);

        // Clear coinciding with an overflowing output transfer: set wins.
        applyStimulus(3'b000, 16'h7FFF, 16'h0001);
        checkOutput("sticky_not_yet", {31'b0, ovf_sticky}, 32'd0);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        checkOutput("sticky_set_wins", {31'b0, ovf_sticky}, 32'd1);

        // Backpressure: three ops offered while the consumer stalls.
        out_ready = 1'b0;
        @(negedge clk);
        in_op = 3'b000; in_a = 16'h0001; in_b = 16'h0001; in_valid = 1'b1;
        checkOutput("bp_ready0", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_op = 3'b011; in_a = 16'h00A0; in_b = 16'h000A;
        @(negedge clk);
        checkOutput("bp_ready1", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_op = 3'b100; in_a = 16'h0F0F; in_b = 16'h00FF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_full_ready%0d", k), {31'b0, in_ready}, 32'd0);
            checkOutput($sformatf("bp_hold_valid%0d", k), {31'b0, out_valid}, 32'd1);
            checkOutput($sformatf("bp_hold_result%0d", k), {16'b0, out_result}, 32'h0002);
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 checkOutput("bp_ready_comb", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        checkOutput("drain1_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("drain1_result", {16'b0, out_result}, 32'h00AA);
        @(posedge clk);
        #1 checkOutput("drain2_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("drain2_result", {16'b0, out_result}, 32'h0FF0);
        @(posedge clk);
        #1 checkOutput("drain_empty", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset with two ops in flight.
        out_ready = 1'b0;
        @(negedge clk);
        in_op = 3'b000; in_a = 16'h7FFF; in_b = 16'h0001; in_valid = 1'b1;
        @(posedge clk);
        #1 in_op = 3'b011; in_a = 16'h1111; in_b = 16'h2222;
        @(posedge clk);
        #1 in_valid = 1'b0;
        checkOutput("inflight_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("inflight_sticky", {31'b0, ovf_sticky}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("async_result", {16'b0, out_result}, 32'd0);
        checkOutput("async_flags", {28'b0, out_c, out_v, out_n, out_z}, 32'd0);
        checkOutput("async_sticky", {31'b0, ovf_sticky}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 checkOutput($sformatf("discarded%0d", k), {31'b0, out_valid}, 32'd0);
        end
        applyStimulus(3'b001, 16'h0010, 16'h0001);
        checkOutput("after_reset_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("after_reset_result", {16'b0, out_result}, 32'h000F);
        checkOutput("after_reset_cvnz", {28'b0, out_c, out_v, out_n, out_z}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
